// File: rtl/lif_spike_monitor.sv
// Spike timestamping event FIFO plus windowed spike-rate counter for the LIF neuron.
// Define LIF_MON_EDGE_DET_EN to qualify spikes on rising edges of spike_in only.
module lif_spike_monitor #(
  parameter int TS_W       = 16,
  parameter int DEPTH      = 8,
  parameter int WIN_CYCLES = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            params_ready,
  input  logic            spike_in,
  input  logic [6:0]      v_mem_in,
  input  logic            evt_ready,
  output logic            evt_valid,
  output logic [TS_W-1:0] evt_ts,
  output logic [6:0]      evt_vmem,
  output logic [7:0]      drop_count,
  output logic [7:0]      rate_out,
  output logic            rate_valid
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int WIN_W   = $clog2(WIN_CYCLES);
  localparam int ENTRY_W = TS_W + 7;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

  logic            armed;
  logic            spike_qual;
  logic            evt_fire;
  logic [TS_W-1:0] ts_reg;
  logic [6:0]      vmem_prev_reg;

  assign armed = enable & params_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_reg <= '0;
    end else if (!params_ready) begin
      ts_reg <= '0;
    end else if (enable) begin
      ts_reg <= ts_reg + TS_W'(1);
    end
  end

  // Holds the potential from the previous armed cycle, i.e. before the neuron's reset on spike.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vmem_prev_reg <= '0;
    end else if (armed) begin
      vmem_prev_reg <= v_mem_in;
    end
  end

`ifdef LIF_MON_EDGE_DET_EN
  logic spike_prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_prev_reg <= 1'b0;
    end else if (armed) begin
      spike_prev_reg <= spike_in;
    end
  end

  assign spike_qual = spike_in & ~spike_prev_reg;
`else
  assign spike_qual = spike_in;
`endif

  assign evt_fire = armed & spike_qual;

  // Event FIFO
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               fifo_empty;
  logic               fifo_full;
  logic               do_pop;
  logic               do_push;
  logic               do_drop;
  logic [7:0]         drop_count_reg;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign do_pop     = ~fifo_empty & evt_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push    = evt_fire & (~fifo_full | do_pop);
  assign do_drop    = evt_fire & fifo_full & ~do_pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= {ts_reg, vmem_prev_reg};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_reg <= '0;
    end else if (do_drop && (drop_count_reg != 8'hFF)) begin
      drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  assign head       = mem[rd_ptr_reg];
  assign evt_valid  = ~fifo_empty;
  assign evt_ts     = fifo_empty ? '0 : head[ENTRY_W-1:7];
  assign evt_vmem   = fifo_empty ? '0 : head[6:0];
  assign drop_count = drop_count_reg;

  // Rate window FSM
  typedef enum logic {
    IDLE,
    COUNT
  } rate_state_t;

  rate_state_t      state_reg;
  rate_state_t      state_next;
  logic [WIN_W-1:0] win_cnt_reg;
  logic [WIN_W-1:0] win_cnt_next;
  logic [7:0]       spike_acc_reg;
  logic [7:0]       spike_acc_next;
  logic [7:0]       rate_out_reg;
  logic [7:0]       rate_out_next;
  logic [7:0]       acc_sum;
  logic             rate_pulse;

  assign acc_sum = (spike_acc_reg == 8'hFF) ? 8'hFF : spike_acc_reg + {7'd0, spike_qual};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      win_cnt_reg   <= '0;
      spike_acc_reg <= '0;
      rate_out_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      win_cnt_reg   <= win_cnt_next;
      spike_acc_reg <= spike_acc_next;
      rate_out_reg  <= rate_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    win_cnt_next   = win_cnt_reg;
    spike_acc_next = spike_acc_reg;
    rate_out_next  = rate_out_reg;
    rate_pulse     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (armed) begin
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (!params_ready) begin
          state_next     = IDLE;
          win_cnt_next   = '0;
          spike_acc_next = '0;
        end else if (enable) begin
          if (win_cnt_reg == WIN_LAST) begin
            rate_out_next  = acc_sum;
            rate_pulse     = 1'b1;
            win_cnt_next   = '0;
            spike_acc_next = '0;
          end else begin
            win_cnt_next   = win_cnt_reg + WIN_W'(1);
            spike_acc_next = acc_sum;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rate_out   = rate_out_reg;
  assign rate_valid = rate_pulse;

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Directed bench for lif_spike_monitor (TS_W=4, DEPTH=8, WIN_CYCLES=16).
// Honours LIF_MON_EDGE_DET_EN for the held-spike scenario.
module tb_lif_spike_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       params_ready;
  logic       spike_in;
  logic [6:0] v_mem_in;
  logic       evt_ready;
  logic       evt_valid;
  logic [3:0] evt_ts;
  logic [6:0] evt_vmem;
  logic [7:0] drop_count;
  logic [7:0] rate_out;
  logic       rate_valid;

  int errors = 0;
  int checks = 0;

  lif_spike_monitor #(
    .TS_W(4),
    .DEPTH(8),
    .WIN_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .params_ready(params_ready),
    .spike_in(spike_in),
    .v_mem_in(v_mem_in),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_ts(evt_ts),
    .evt_vmem(evt_vmem),
    .drop_count(drop_count),
    .rate_out(rate_out),
    .rate_valid(rate_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; params_ready = 1'b0;
    spike_in = 1'b0; v_mem_in = '0; evt_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; params_ready = 1'b1;
    spike_in = 1'b0; v_mem_in = '0; evt_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    enable = 1'b1;
    // events at ts 0,2,4; one full rate window completes with 2 spikes
    for (int k = 0; k < 18; k++) begin
      spike_in = (k == 0 || k == 2 || k == 4);
      tick();
    end
    spike_in = 1'b0;
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %0d expected 1", evt_valid); end
    checks++; if (evt_ts !== 4'd0) begin errors++; $display("FAIL pre_reset_head_ts: got %0d expected 0", evt_ts); end
    checks++; if (rate_out !== 8'd2) begin errors++; $display("FAIL pre_reset_rate: got %0d expected 2", rate_out); end
    reset = 1'b1;
    #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", evt_valid); end
    checks++; if (evt_ts !== 4'd0) begin errors++; $display("FAIL reset_ts_out: got %0d expected 0", evt_ts); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    checks++; if (rate_out !== 8'd0) begin errors++; $display("FAIL reset_rate: got %0d expected 0", rate_out); end
    enable = 1'b0;
    tick();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %0d expected 0", evt_valid); end
    reset = 1'b0;
    enable = 1'b1;
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid: got %0d expected 1", evt_valid); end
    checks++; if (evt_ts !== 4'd0) begin errors++; $display("FAIL post_reset_ts: got %0d expected 0", evt_ts); end
    $display("test_reset: head ts=%0d drop=%0d rate=%0d", evt_ts, drop_count, rate_out);
  endtask

  task automatic test_single_spike();
    do_reset();
    enable = 1'b1;
    params_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      v_mem_in = (c == 9) ? 7'd42 : 7'(c + 20);
      spike_in = (c == 10);
      if (c == 10) begin
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0d expected 0", evt_valid); end
      end
      tick();
    end
    spike_in = 1'b0;
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0d expected 1", evt_valid); end
    checks++; if (evt_ts !== 4'd10) begin errors++; $display("FAIL single_ts: got %0d expected 10", evt_ts); end
    checks++; if (evt_vmem !== 7'd42) begin errors++; $display("FAIL single_vmem: got %0d expected 42", evt_vmem); end
    $display("test_single_spike: pop ts=%0d vmem=%0d", evt_ts, evt_vmem);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_popped_valid: got %0d expected 0", evt_valid); end
    checks++; if (evt_ts !== 4'd0) begin errors++; $display("FAIL single_empty_ts: got %0d expected 0", evt_ts); end
    checks++; if (evt_vmem !== 7'd0) begin errors++; $display("FAIL single_empty_vmem: got %0d expected 0", evt_vmem); end
  endtask

  task automatic test_overflow();
    logic [3:0] exp_ts [8];
    do_reset();
    enable = 1'b1;
    params_ready = 1'b1;
    // spikes at ts 0,2,..,14 fill the FIFO; ts 0 and 2 after the wrap are dropped
    for (int k = 0; k < 20; k++) begin
      spike_in = (k % 2 == 0);
      tick();
    end
    spike_in = 1'b0;
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL overflow_drop: got %0d expected 2", drop_count); end
    checks++; if (evt_ts !== 4'd0) begin errors++; $display("FAIL overflow_head: got %0d expected 0", evt_ts); end
    // cycle 20 (ts 4): push with pop while full
    spike_in = 1'b1;
    evt_ready = 1'b1;
    tick();
    spike_in = 1'b0;
    evt_ready = 1'b0;
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL full_push_pop_drop: got %0d expected 2", drop_count); end
    tick();
    // cycle 22: still full, so this one is dropped
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
    checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL still_full_drop: got %0d expected 3", drop_count); end
    for (int i = 0; i < 7; i++) exp_ts[i] = 4'(2 * i + 2);
    exp_ts[7] = 4'd4;
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL overflow_drain_valid[%0d]: got %0d expected 1", i, evt_valid); end
      checks++; if (evt_ts !== exp_ts[i]) begin errors++; $display("FAIL overflow_drain_ts[%0d]: got %0d expected %0d", i, evt_ts, exp_ts[i]); end
      $display("test_overflow: pop %0d ts=%0d", i, evt_ts);
      tick();
    end
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL overflow_drained: got %0d expected 0", evt_valid); end
  endtask

  task automatic test_rate_window();
    do_reset();
    enable = 1'b1;
    params_ready = 1'b1;
    evt_ready = 1'b1;
    // cycle 0 enters COUNT; window covers cycles 1..16
    for (int k = 0; k <= 16; k++) begin
      spike_in = (k == 2 || k == 4 || k == 6 || k == 8 || k == 10);
      if (k == 15) begin
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL win1_early_pulse: got %0d expected 0", rate_valid); end
      end
      if (k == 16) begin
        checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL win1_pulse: got %0d expected 1", rate_valid); end
        checks++; if (rate_out !== 8'd0) begin errors++; $display("FAIL win1_rate_before: got %0d expected 0", rate_out); end
      end
      tick();
    end
    spike_in = 1'b1;
    checks++; if (rate_out !== 8'd5) begin errors++; $display("FAIL win1_rate: got %0d expected 5", rate_out); end
    checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL win1_pulse_width: got %0d expected 0", rate_valid); end
    $display("test_rate_window: window1 rate=%0d", rate_out);
    tick();
    spike_in = 1'b0;
    params_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if (rate_out !== 8'd5) begin errors++; $display("FAIL rate_hold: got %0d expected 5", rate_out); end
    params_ready = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      spike_in = (j == 3 || j == 5 || j == 16);
      if (j == 15) begin
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL win2_early_pulse: got %0d expected 0", rate_valid); end
      end
      if (j == 16) begin
        checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL win2_pulse: got %0d expected 1", rate_valid); end
        checks++; if (rate_out !== 8'd5) begin errors++; $display("FAIL win2_rate_before: got %0d expected 5", rate_out); end
      end
      tick();
    end
    spike_in = 1'b0;
    checks++; if (rate_out !== 8'd3) begin errors++; $display("FAIL win2_rate: got %0d expected 3", rate_out); end
    $display("test_rate_window: window2 rate=%0d", rate_out);
    evt_ready = 1'b0;
  endtask

  task automatic test_ts_wrap();
    logic [3:0] exp_ts [3];
    do_reset();
    enable = 1'b1;
    params_ready = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      spike_in = (k == 15 || k == 32);
      tick();
    end
    enable = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    enable = 1'b1;
    spike_in = 1'b0;
    tick();
    spike_in = 1'b1;
    tick();
    spike_in = 1'b0;
    exp_ts[0] = 4'd15; exp_ts[1] = 4'd0; exp_ts[2] = 4'd2;
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d]: got %0d expected 1", i, evt_valid); end
      checks++; if (evt_ts !== exp_ts[i]) begin errors++; $display("FAIL wrap_ts[%0d]: got %0d expected %0d", i, evt_ts, exp_ts[i]); end
      $display("test_ts_wrap: pop %0d ts=%0d", i, evt_ts);
      tick();
    end
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained: got %0d expected 0", evt_valid); end
  endtask

  task automatic test_held_high();
    logic [3:0] exp_ts [3];
    int n_exp;
    do_reset();
    enable = 1'b1;
    params_ready = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      spike_in = (k >= 3 && k <= 5);
      tick();
    end
    spike_in = 1'b0;
`ifdef LIF_MON_EDGE_DET_EN
    n_exp = 1;
`else
    n_exp = 3;
`endif
    exp_ts[0] = 4'd3; exp_ts[1] = 4'd4; exp_ts[2] = 4'd5;
    evt_ready = 1'b1;
    for (int i = 0; i < n_exp; i++) begin
      checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL held_valid[%0d]: got %0d expected 1", i, evt_valid); end
      checks++; if (evt_ts !== exp_ts[i]) begin errors++; $display("FAIL held_ts[%0d]: got %0d expected %0d", i, evt_ts, exp_ts[i]); end
      $display("test_held_high: pop %0d ts=%0d", i, evt_ts);
      tick();
    end
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL held_count: got %0d expected 0 after %0d pops", evt_valid, n_exp); end
  endtask

  initial begin
    test_reset();
    test_single_spike();
    test_overflow();
    test_rate_window();
    test_ts_wrap();
    test_held_high();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
